// File: rtl/rr_bus_sched_if.sv
// Bus bundle between the round-robin scheduler and its attached devices.
// The scheduler takes the master side; the device array takes the slave side.
interface rr_bus_sched_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;
    logic                     busy;
    logic [15:0]              drop_cnt;

    modport master (input pndng, D_pop, output pop, push, D_push, busy, drop_cnt);
    modport slave  (output pndng, D_pop, input pop, push, D_push, busy, drop_cnt);
endinterface

// File: rtl/rr_bus_sched.sv
// Round-robin bus scheduler: pops one packet from a granted device, then pushes it
// to its destination (unicast or broadcast), counting undeliverable packets as drops.
module rr_bus_sched #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    rr_bus_sched_if.master bus
);
    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic               busy_q, busy_d;
    logic [15:0]        drop_q, drop_d;

    logic [pckg_sz-1:0] slot [drvrs];
    logic [GW-1:0]      rr_pick;
    logic               rr_hit;
    int                 idx;
    logic [7:0]         dest;
    logic               is_bcast;
    logic               dest_ok;

    for (genvar i = 0; i < drvrs; i++) begin : g_slot
        assign slot[i] = bus.D_pop[i*pckg_sz +: pckg_sz];
    end

    assign dest     = pkt_q[pckg_sz-1 -: 8];
    assign is_bcast = (dest == broadcast);
    assign dest_ok  = ({24'd0, dest} < 32'(drvrs)) && (dest != 8'(grant_q));

    // Scan farthest-first so the device nearest after last_q wins.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = last_q;
        idx     = 0;
        for (int off = drvrs; off >= 1; off--) begin
            idx = (int'(last_q) + off) % drvrs;
            if (bus.pndng[GW'(idx)]) begin
                rr_hit  = 1'b1;
                rr_pick = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (rr_hit) begin
                state_d = POP;
                grant_d = rr_pick;
            end
            POP:     state_d = bus.pndng[grant_q] ? PUSH : IDLE;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_d   = '0;
        push_d  = '0;
        pkt_d   = pkt_q;
        dpush_d = dpush_q;
        drop_d  = drop_q;
        last_d  = last_q;
        busy_d  = (state_d != IDLE);
        case (state_q)
            POP: if (bus.pndng[grant_q]) begin
                pop_d[grant_q] = 1'b1;
                pkt_d          = slot[grant_q];
            end
            PUSH: begin
                last_d = grant_q;
                if (is_bcast) begin
                    push_d          = '1;
                    push_d[grant_q] = 1'b0;
                    dpush_d         = pkt_q;
                end else if (dest_ok) begin
                    push_d[dest[GW-1:0]] = 1'b1;
                    dpush_d              = pkt_q;
                end else if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_q   <= '0;
            push_q  <= '0;
            pkt_q   <= '0;
            dpush_q <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
            last_q  <= GW'(drvrs - 1);
        end else begin
            pop_q   <= pop_d;
            push_q  <= push_d;
            pkt_q   <= pkt_d;
            dpush_q <= dpush_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.D_push   = dpush_q;
    assign bus.busy     = busy_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_rr_bus_sched.sv
// Directed bench for rr_bus_sched: device FIFO model feeds the bus, a scoreboard
// queue holds the expected pop/push events in order.
module tb_rr_bus_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rr_bus_sched_if #(.drvrs(4), .pckg_sz(16)) bus ();

    rr_bus_sched #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  pop;
        logic [3:0]  push;
        logic [15:0] d;
    } ev_t;

    ev_t         exq [$];
    logic [15:0] fifo [4][$];
    logic [3:0]  force_pnd = 4'h0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          exp_drops = 0;
    int          p0 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.pndng[i]         = (fifo[i].size() != 0) | force_pnd[i];
            bus.D_pop[i*16 +: 16] = (fifo[i].size() != 0) ? fifo[i][0] : 16'h0;
        end
    endtask

    // Expected events for one packet: a pop from src, then a push unless dropped.
    task automatic expect_pkt(input int src, input logic [15:0] pkt);
        ev_t        e;
        logic [7:0] dst;
        dst    = pkt[15:8];
        e.pop  = 4'(1 << src);
        e.push = 4'h0;
        e.d    = 16'h0;
        exq.push_back(e);
        if (dst == 8'hFF)                 e.push = 4'hF & ~4'(1 << src);
        else if (dst < 4 && dst != src)   e.push = 4'(1 << dst);
        if (e.push != 4'h0) begin
            e.pop = 4'h0;
            e.d   = pkt;
            exq.push_back(e);
        end else begin
            exp_drops++;
        end
    endtask

    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.pop !== 4'h0 || bus.push !== 4'h0) begin
            chk("sb_expected", 32'(exq.size() != 0), 32'd1);
            if (exq.size() != 0) begin
                e = exq.pop_front();
                chk("sb_pop", 32'(bus.pop), 32'(e.pop));
                chk("sb_push", 32'(bus.push), 32'(e.push));
                if (e.push != 4'h0) chk("sb_dpush", 32'(bus.D_push), 32'(e.d));
            end
        end
        if (bus.pop[0] === 1'b1) p0.push_back(cyc);
        for (int i = 0; i < 4; i++)
            if (bus.pop[i] === 1'b1 && fifo[i].size() != 0) void'(fifo[i].pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 80 && exq.size() != 0; n++) tick();
        chk(tag, 32'(exq.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        drive();
        // reset state
        tick();
        tick();
        chk("rst_pop", 32'(bus.pop), 32'd0);
        chk("rst_push", 32'(bus.push), 32'd0);
        chk("rst_dpush", 32'(bus.D_push), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);

        // unicast 1 -> 3 with exact latency
        reset = 1'b1;
        fifo[1].push_back(16'h03AB);
        expect_pkt(1, 16'h03AB);
        drive();
        tick();
        chk("uc_busy_pop_state", 32'(bus.busy), 32'd1);
        chk("uc_no_pop_yet", 32'(bus.pop), 32'd0);
        tick();
        chk("uc_pop", 32'(bus.pop), 32'b0010);
        tick();
        chk("uc_push", 32'(bus.push), 32'b1000);
        chk("uc_dpush", 32'(bus.D_push), 32'h03AB);
        chk("uc_busy_done", 32'(bus.busy), 32'd0);
        tick();
        chk("uc_dpush_hold", 32'(bus.D_push), 32'h03AB);
        chk("uc_push_off", 32'(bus.push), 32'd0);

        // round robin from fresh reset: 0,1,2,3,0
        reset = 1'b0;
        tick();
        exp_drops = 0;
        reset = 1'b1;
        p0.delete();
        fifo[0].push_back(16'h0111); fifo[0].push_back(16'h0244);
        fifo[1].push_back(16'h0211);
        fifo[2].push_back(16'h0322);
        fifo[3].push_back(16'h0033);
        expect_pkt(0, 16'h0111);
        expect_pkt(1, 16'h0211);
        expect_pkt(2, 16'h0322);
        expect_pkt(3, 16'h0033);
        expect_pkt(0, 16'h0244);
        drive();
        drain("rr_drain");
        chk("rr_p0_pops", 32'(p0.size()), 32'd2);
        if (p0.size() >= 2) chk("rr_period", 32'(p0[1] - p0[0]), 32'd12);
        chk("rr_no_drop", 32'(bus.drop_cnt), 32'(exp_drops));

        // broadcast from device 2
        fifo[2].push_back(16'hFF55);
        expect_pkt(2, 16'hFF55);
        drive();
        drain("bc_drain");

        // drops: out-of-range destination, then self-destination
        fifo[0].push_back(16'h0711);
        fifo[0].push_back(16'h0022);
        expect_pkt(0, 16'h0711);
        expect_pkt(0, 16'h0022);
        drive();
        drain("drop_drain");
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drops));
        chk("drop_cnt_two", 32'(exp_drops), 32'd2);

        // withdrawn one-cycle request from device 3
        force_pnd = 4'b1000;
        drive();
        force_pnd = 4'b0000;
        tick();
        chk("wd_busy_high", 32'(bus.busy), 32'd1);
        tick();
        chk("wd_busy_low", 32'(bus.busy), 32'd0);
        chk("wd_no_pop", 32'(bus.pop), 32'd0);
        tick();
        tick();
        chk("wd_no_push", 32'(bus.push), 32'd0);
        chk("wd_drop_same", 32'(bus.drop_cnt), 32'(exp_drops));

        // reset while pop is high aborts the transfer
        fifo[1].push_back(16'h0203);
        exq.push_back('{pop: 4'b0010, push: 4'h0, d: 16'h0});
        drive();
        tick();
        tick();
        chk("rm_pop_seen", 32'(bus.pop), 32'b0010);
        reset = 1'b0;
        tick();
        chk("rm_push", 32'(bus.push), 32'd0);
        chk("rm_busy", 32'(bus.busy), 32'd0);
        chk("rm_drop", 32'(bus.drop_cnt), 32'd0);
        exp_drops = 0;
        reset = 1'b1;
        fifo[2].push_back(16'h0311);
        fifo[0].push_back(16'h0122);
        expect_pkt(0, 16'h0122);
        expect_pkt(2, 16'h0311);
        drive();
        drain("rm_after_release");
        chk("rm_final_drop", 32'(bus.drop_cnt), 32'(exp_drops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
